// File: rtl/axi4_burst_reader_if.sv
// -----------------------------------------------------------------------------
// axi4_burst_reader_if
// AXI4 read-address (AR) and read-data (R) channel bundle used by the burst
// reader. Only the subset of AR/R signals the reader needs is carried.
//
// Signals:
//   m_axi_araddr   burst start byte address
//   m_axi_arlen    beats - 1
//   m_axi_arsize   bytes per beat (log2)
//   m_axi_arburst  burst type
//   m_axi_arvalid / m_axi_arready   AR handshake
//   m_axi_rdata    read data
//   m_axi_rresp    read response
//   m_axi_rlast    last beat of burst
//   m_axi_rvalid / m_axi_rready     R handshake
//
// Modports: master (the reader), slave (the memory / bench model).
// -----------------------------------------------------------------------------
interface axi4_burst_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/axi4_burst_reader.sv
// -----------------------------------------------------------------------------
// axi4_burst_reader
// AXI4 read-only burst master. Fetches i_num_words contiguous 32-bit words
// starting at i_src_addr and writes them to consecutive BRAM word addresses
// starting at i_bram_base. Bursts never cross a 4 KB boundary and never
// exceed MAX_BURST_LEN beats; one burst is outstanding at a time.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   i_start                     one-cycle request, sampled only when idle
//   i_src_addr                  source byte address (bits [1:0] ignored)
//   i_num_words                 number of words to move (0 = no traffic)
//   i_bram_base                 first BRAM word address
//   o_busy, o_done, o_error     status: busy level, done pulse, sticky error
//   axi (master modport)        AR / R channels
//   o_bram_addr/_din/_we        registered BRAM write port
// -----------------------------------------------------------------------------
module axi4_burst_reader #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_BURST_LEN      = 16,
  parameter int LEN_WIDTH          = 16,
  parameter int BRAM_ADDRESS_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_src_addr,
  input  logic [LEN_WIDTH-1:0]          i_num_words,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] i_bram_base,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  axi4_burst_reader_if.master           axi,
  output logic [BRAM_ADDRESS_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0]         o_bram_din,
  output logic                          o_bram_we
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [ADDR_WIDTH-1:0]         addr_reg;
  logic [LEN_WIDTH-1:0]          remaining_reg;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_ptr_reg;
  logic [7:0]                    arlen_reg;
  logic [7:0]                    beat_idx_reg;
  logic                          error_reg;
  logic                          bram_we_reg;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_reg;
  logic [DATA_WIDTH-1:0]         bram_din_reg;

  // Burst sizing for the pending address: min(remaining, max burst, words
  // left before the next 4 KB page). addr_reg[11:2] is at most 1023, so
  // the boundary distance is always 1..1024 words and never zero.
  logic [31:0] words_to_boundary;
  logic [31:0] burst_cap;
  logic [7:0]  burst_arlen;

  always_comb begin
    words_to_boundary = 32'(11'h400 - {1'b0, addr_reg[11:2]});
    burst_cap         = 32'(MAX_BURST_LEN);
    if (32'(remaining_reg) < burst_cap) begin
      burst_cap = 32'(remaining_reg);
    end
    if (words_to_boundary < burst_cap) begin
      burst_cap = words_to_boundary;
    end
    burst_arlen = 8'(burst_cap - 32'd1);
  end

  // Burst termination is decided by the beat counter alone; rlast is only
  // cross-checked for the error flag.
  logic                 burst_end;
  logic [8:0]           burst_beats;
  logic [LEN_WIDTH-1:0] remaining_after;

  assign burst_end       = (beat_idx_reg == arlen_reg);
  assign burst_beats     = {1'b0, arlen_reg} + 9'd1;
  assign remaining_after = remaining_reg - LEN_WIDTH'(burst_beats);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = (i_num_words == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (axi.m_axi_arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (axi.m_axi_rvalid && burst_end) begin
          state_next = (remaining_after != '0) ? ADDR : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      bram_ptr_reg  <= '0;
      arlen_reg     <= '0;
      beat_idx_reg  <= '0;
      error_reg     <= 1'b0;
      bram_we_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
    end else begin
      bram_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            addr_reg      <= i_src_addr & ~ADDR_WIDTH'(3);
            remaining_reg <= i_num_words;
            bram_ptr_reg  <= i_bram_base;
            error_reg     <= 1'b0;
          end
        end
        ADDR: begin
          if (axi.m_axi_arready) begin
            arlen_reg    <= burst_arlen;
            beat_idx_reg <= '0;
          end
        end
        DATA: begin
          if (axi.m_axi_rvalid) begin
            bram_we_reg   <= 1'b1;
            bram_addr_reg <= bram_ptr_reg;
            bram_din_reg  <= axi.m_axi_rdata;
            bram_ptr_reg  <= bram_ptr_reg + 1'b1;
            beat_idx_reg  <= beat_idx_reg + 8'd1;
            if ((axi.m_axi_rresp != 2'b00) || (axi.m_axi_rlast != burst_end)) begin
              error_reg <= 1'b1;
            end
            if (burst_end) begin
              addr_reg      <= addr_reg + ADDR_WIDTH'({burst_beats, 2'b00});
              remaining_reg <= remaining_after;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // While arvalid is up, arlen is the live sizing result; the inputs to it
  // are frozen in ADDR, so it stays stable until the handshake.
  assign axi.m_axi_araddr  = addr_reg;
  assign axi.m_axi_arlen   = (state_reg == ADDR) ? burst_arlen : arlen_reg;
  assign axi.m_axi_arsize  = 3'b010;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arvalid = (state_reg == ADDR);
  assign axi.m_axi_rready  = (state_reg == DATA);

  assign o_busy      = (state_reg != IDLE);
  assign o_done      = (state_reg == DONE);
  assign o_error     = error_reg;
  assign o_bram_we   = bram_we_reg;
  assign o_bram_addr = bram_addr_reg;
  assign o_bram_din  = bram_din_reg;

endmodule

// File: tb/tb_axi4_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_axi4_burst_reader
// Bench for axi4_burst_reader: a behavioural AXI memory slave with optional
// stalls and fault injection, a transfer-level model that predicts bursts,
// BRAM writes and status timing, and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_axi4_burst_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_start = 1'b0;
  logic [31:0] i_src_addr = '0;
  logic [15:0] i_num_words = '0;
  logic [15:0] i_bram_base = '0;
  logic        o_busy, o_done, o_error;
  logic [15:0] o_bram_addr;
  logic [31:0] o_bram_din;
  logic        o_bram_we;

  axi4_burst_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_burst_reader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST_LEN(16),
    .LEN_WIDTH(16), .BRAM_ADDRESS_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_num_words(i_num_words), .i_bram_base(i_bram_base),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .axi(axi),
    .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din), .o_bram_we(o_bram_we)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[17:2]};
  endfunction

  // Burst plan from the sizing rules: min(remaining, 16, words to 4 KB).
  logic [31:0] pa[$];
  int          pl[$];
  function automatic void calc_bursts(input logic [31:0] src, input int n);
    logic [31:0] a;
    int rem, c, wtb;
    pa.delete();
    pl.delete();
    a   = src & ~32'h3;
    rem = n;
    while (rem > 0) begin
      wtb = (4096 - int'(a[11:0])) / 4;
      c = rem;
      if (c > 16) c = 16;
      if (wtb < c) c = wtb;
      pa.push_back(a);
      pl.push_back(c - 1);
      a   = a + 32'(4 * c);
      rem = rem - c;
    end
  endfunction

  // ---------------- AXI slave model ----------------
  int ar_stall = 0;
  int r_stall = 0;
  int err_beat = -1;
  int bad_last_beat = -1;
  int gbeat = 0;

  initial begin : slave
    bit          s_active, ar_hs, r_hs;
    logic [31:0] s_addr, ar_a;
    int          s_len, s_beat, ar_l;
    s_active = 0; s_addr = '0; s_len = 0; s_beat = 0;
    axi.m_axi_arready = 1'b0;
    axi.m_axi_rvalid  = 1'b0;
    axi.m_axi_rdata   = '0;
    axi.m_axi_rresp   = 2'b00;
    axi.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = resetn && axi.m_axi_arvalid && axi.m_axi_arready;
      r_hs  = resetn && axi.m_axi_rvalid && axi.m_axi_rready;
      ar_a  = axi.m_axi_araddr;
      ar_l  = int'(axi.m_axi_arlen);
      @(posedge clk);
      #1;
      if (!resetn) begin
        s_active = 0;
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rlast   = 1'b0;
        axi.m_axi_rresp   = 2'b00;
        continue;
      end
      if (r_hs) begin
        s_beat++;
        gbeat++;
        if (s_beat > s_len) s_active = 0;
      end
      if (ar_hs) begin
        s_active = 1; s_addr = ar_a; s_len = ar_l; s_beat = 0;
      end
      axi.m_axi_arready = !s_active && ($urandom_range(99) >= 32'(ar_stall));
      axi.m_axi_rvalid  = s_active && ($urandom_range(99) >= 32'(r_stall));
      axi.m_axi_rdata   = mem_word(s_addr + 32'(4 * s_beat));
      axi.m_axi_rresp   = (gbeat == err_beat) ? 2'b10 : 2'b00;
      axi.m_axi_rlast   = s_active && ((s_beat == s_len) || (gbeat == bad_last_beat));
    end
  end

  // ---------------- model + per-cycle compare ----------------
  logic [31:0] eb_a[$];
  int          eb_l[$];
  logic [15:0] ew_a[$];
  logic [31:0] ew_d[$];
  logic [31:0] seen_a[$];
  int          seen_l[$];
  int          n_writes = 0;
  int          n_dones = 0;
  bit          m_busy, m_done, m_err, m_rready, m_ar;
  bit          p_arvalid, p_hs;
  logic [31:0] p_araddr;
  logic [7:0]  p_arlen;
  int          cur_len, cur_beat;

  always @(negedge clk) begin : monitor
    bit nx_busy, nx_done, nx_err, nx_rready, nx_ar, last;
    if (!resetn) begin
      chk("reset_ctl", 32'({axi.m_axi_arvalid, axi.m_axi_rready, o_bram_we, o_busy, o_done, o_error}), 32'h0);
      chk("reset_const", 32'({axi.m_axi_arsize, axi.m_axi_arburst}), 32'h09);
      chk("reset_bus", axi.m_axi_araddr | o_bram_din | 32'(o_bram_addr) | 32'(axi.m_axi_arlen), 32'h0);
      eb_a.delete(); eb_l.delete(); ew_a.delete(); ew_d.delete();
      m_busy = 0; m_done = 0; m_err = 0; m_rready = 0; m_ar = 0;
      p_arvalid = 0; p_hs = 0; cur_len = 0; cur_beat = 0;
    end else begin
      nx_busy = m_busy; nx_err = m_err; nx_rready = m_rready;
      nx_done = 0; nx_ar = 0;
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("done", 32'(o_done), 32'(m_done));
      chk("error", 32'(o_error), 32'(m_err));
      chk("rready", 32'(axi.m_axi_rready), 32'(m_rready));
      if (m_ar) chk("arvalid_latency", 32'(axi.m_axi_arvalid), 32'h1);
      if (o_done) n_dones++;
      if (axi.m_axi_arvalid) begin
        if (eb_a.size() == 0) begin
          chk("ar_unexpected", 32'(axi.m_axi_arvalid), 32'h0);
        end else if (p_arvalid && !p_hs) begin
          chk("araddr_stable", axi.m_axi_araddr, p_araddr);
          chk("arlen_stable", 32'(axi.m_axi_arlen), 32'(p_arlen));
        end
      end
      if (axi.m_axi_arvalid && axi.m_axi_arready && eb_a.size() > 0) begin
        chk("araddr", axi.m_axi_araddr, eb_a[0]);
        chk("arlen", 32'(axi.m_axi_arlen), 32'(eb_l[0]));
        seen_a.push_back(axi.m_axi_araddr);
        seen_l.push_back(int'(axi.m_axi_arlen));
        cur_len = eb_l.pop_front();
        void'(eb_a.pop_front());
        cur_beat = 0;
        nx_rready = 1;
      end
      if (o_bram_we) begin
        if (ew_a.size() == 0) begin
          chk("we_unexpected", 32'(o_bram_we), 32'h0);
        end else begin
          chk("bram_addr", 32'(o_bram_addr), 32'(ew_a.pop_front()));
          chk("bram_din", o_bram_din, ew_d.pop_front());
          n_writes++;
        end
      end
      if (m_done) chk("writes_left_at_done", 32'(ew_a.size()), 32'h0);
      if (axi.m_axi_rvalid && axi.m_axi_rready) begin
        last = (cur_beat == cur_len);
        if ((axi.m_axi_rresp != 2'b00) || (axi.m_axi_rlast != last)) nx_err = 1;
        cur_beat++;
        if (last) begin
          nx_rready = 0;
          if (eb_a.size() == 0) nx_done = 1;
          else nx_ar = 1;
        end
      end
      if (m_done) nx_busy = 0;
      if (i_start && !m_busy) begin
        calc_bursts(i_src_addr, int'(i_num_words));
        eb_a = pa;
        eb_l = pl;
        for (int k = 0; k < int'(i_num_words); k++) begin
          ew_a.push_back(i_bram_base + 16'(k));
          ew_d.push_back(mem_word((i_src_addr & ~32'h3) + 32'(4 * k)));
        end
        nx_err = 0;
        nx_busy = 1;
        if (i_num_words == 16'd0) nx_done = 1;
        else nx_ar = 1;
      end
      p_arvalid = axi.m_axi_arvalid;
      p_hs      = axi.m_axi_arvalid && axi.m_axi_arready;
      p_araddr  = axi.m_axi_araddr;
      p_arlen   = axi.m_axi_arlen;
      m_busy = nx_busy; m_done = nx_done; m_err = nx_err;
      m_rready = nx_rready; m_ar = nx_ar;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_xfer(input logic [31:0] src, input int n, input logic [15:0] base);
    @(posedge clk);
    #1;
    seen_a.delete(); seen_l.delete();
    n_writes = 0; n_dones = 0; gbeat = 0;
    i_src_addr = src; i_num_words = 16'(n); i_bram_base = base; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (o_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (o_busy) chk(name, 32'(o_busy), 32'h0);
    $display("xfer src=%h words=%0d bursts=%0d writes=%0d dones=%0d error=%0b",
             i_src_addr, i_num_words, seen_a.size(), n_writes, n_dones, o_error);
  endtask

  initial begin : stim
    int k;
    // Pin the burst planner itself against hand-computed plans.
    calc_bursts(32'h1000, 40);
    chk("plan1_n", 32'(pa.size()), 32'd3);
    chk("plan1_a0", pa[0], 32'h1000); chk("plan1_l0", 32'(pl[0]), 32'd15);
    chk("plan1_a1", pa[1], 32'h1040); chk("plan1_l1", 32'(pl[1]), 32'd15);
    chk("plan1_a2", pa[2], 32'h1080); chk("plan1_l2", 32'(pl[2]), 32'd7);
    calc_bursts(32'h0FF8, 10);
    chk("plan2_n", 32'(pa.size()), 32'd2);
    chk("plan2_a0", pa[0], 32'h0FF8); chk("plan2_l0", 32'(pl[0]), 32'd1);
    chk("plan2_a1", pa[1], 32'h1000); chk("plan2_l1", 32'(pl[1]), 32'd7);

    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;

    // 1: 40 words, no stalls
    start_xfer(32'h1000, 40, 16'h0010);
    wait_idle("t1_timeout", 300);
    chk("t1_writes", 32'(n_writes), 32'd40);
    chk("t1_dones", 32'(n_dones), 32'd1);
    chk("t1_bursts", 32'(seen_a.size()), 32'd3);
    if (seen_a.size() == 3) begin
      chk("t1_ar0", seen_a[0], 32'h1000); chk("t1_len0", 32'(seen_l[0]), 32'd15);
      chk("t1_ar1", seen_a[1], 32'h1040); chk("t1_len1", 32'(seen_l[1]), 32'd15);
      chk("t1_ar2", seen_a[2], 32'h1080); chk("t1_len2", 32'(seen_l[2]), 32'd7);
    end
    chk("t1_error", 32'(o_error), 32'h0);

    // 2: 4 KB split, with an ignored start while busy
    start_xfer(32'h0FF8, 10, 16'h0100);
    repeat (4) @(posedge clk);
    #1;
    i_src_addr = 32'h9000; i_num_words = 16'd3; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle("t2_timeout", 300);
    chk("t2_writes", 32'(n_writes), 32'd10);
    chk("t2_bursts", 32'(seen_a.size()), 32'd2);
    if (seen_a.size() == 2) begin
      chk("t2_ar0", seen_a[0], 32'h0FF8); chk("t2_len0", 32'(seen_l[0]), 32'd1);
      chk("t2_ar1", seen_a[1], 32'h1000); chk("t2_len1", 32'(seen_l[1]), 32'd7);
    end

    // 3: 50% stalls, 33 words, BRAM pointer wraps, unaligned low bits
    ar_stall = 50; r_stall = 50;
    start_xfer(32'h2006, 33, 16'hFFF0);
    wait_idle("t3_timeout", 3000);
    ar_stall = 0; r_stall = 0;
    chk("t3_writes", 32'(n_writes), 32'd33);
    chk("t3_dones", 32'(n_dones), 32'd1);
    chk("t3_bursts", 32'(seen_a.size()), 32'd3);

    // 4: SLVERR on beat 3
    err_beat = 3;
    start_xfer(32'h3000, 16, 16'h0000);
    wait_idle("t4_timeout", 300);
    err_beat = -1;
    chk("t4_writes", 32'(n_writes), 32'd16);
    chk("t4_error", 32'(o_error), 32'h1);

    // 5: early rlast on beat 5
    bad_last_beat = 5;
    start_xfer(32'h4000, 16, 16'h0020);
    wait_idle("t5_timeout", 300);
    bad_last_beat = -1;
    chk("t5_writes", 32'(n_writes), 32'd16);
    chk("t5_error", 32'(o_error), 32'h1);

    // 6: zero-word request
    start_xfer(32'h5000, 0, 16'h0000);
    wait_idle("t6_timeout", 50);
    chk("t6_error", 32'(o_error), 32'h0);
    chk("t6_bursts", 32'(seen_a.size()), 32'd0);
    chk("t6_dones", 32'(n_dones), 32'd1);

    // 7: reset during the second burst, then a normal 4-word transfer
    start_xfer(32'h1000, 40, 16'h0000);
    k = 0;
    while (seen_a.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (seen_a.size() < 2) chk("t7_second_burst_timeout", 32'(seen_a.size()), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("t7_in_data", 32'(axi.m_axi_rready), 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk("t7_async_drop", 32'({axi.m_axi_arvalid, axi.m_axi_rready, o_bram_we, o_busy}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    start_xfer(32'h6000, 4, 16'h0040);
    wait_idle("t7_timeout", 100);
    chk("t7_writes", 32'(n_writes), 32'd4);
    chk("t7_dones", 32'(n_dones), 32'd1);
    chk("t7_error", 32'(o_error), 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
